ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 5-stage processor; sits directly downstream of the reduction unit and the ALU adders.
- Captures the EX-stage result and selects the reduction unit's 7-bit signed sum for RED. It sign-extends that sum to 16 bits and registers it with destination and control bits for MEM.
- Owns the architectural N/V/Z flag register used by the branch unit.
- Implements stall, flush and sticky halt.

Parameters:
- DW, 16, datapath width.
- RW, 7, width of the reduction-unit result.
- AW, 4, register-file index width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all state (MEM stalled).
- flush  in  1  squash the instruction in EX (branch taken).
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  4  instruction opcode.
- ex_alu_out  in  DW  ALU/adder result for non-RED ops.
- ex_red_out  in  RW  reduction-unit signed sum.
- ex_ovf  in  1  overflow/saturation indication from the EX adder.
- ex_rd  in  AW  destination register.
- ex_reg_wr  in  1  register write enable.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_store_data  in  DW  store data.
- mem_valid  out  1  MEM holds a real instruction.
- mem_result  out  DW  registered result / address.
- mem_rd  out  AW  registered destination.
- mem_reg_wr  out  1  registered register write enable.
- mem_mem_rd  out  1  registered load.
- mem_mem_wr  out  1  registered store.
- mem_store_data  out  DW  registered store data.
- flags  out  3  {N,V,Z} architectural flags.
- halted  out  1  sticky; a HLT has reached MEM.

Behaviour:
- Reset, synchronous, highest priority: all mem_* outputs are 0, flags = 3'b000, halted = 0.
- Latency is one cycle EX -> MEM. All outputs are registered; there are no combinational paths from inputs to outputs.
- Per-edge priority is rst > halted > flush > stall > load.
- Opcodes: ADD=0, SUB=1, XOR=2, RED=3, SLL=4, SRA=5, ROR=6, PADDSB=7, LW=8, SW=9, LLB=A, LHB=B, B=C, BR=D, PCS=E, HLT=F.
- Result select: if ex_opcode==RED, result = {{(DW-RW){ex_red_out[RW-1]}}, ex_red_out}. Otherwise result = ex_alu_out.
- Load (no stall, no flush): capture all ex_* fields; mem_valid = ex_valid. If ex_valid=0, all write/memory enables are forced to 0.
- Flush (stall don't-care): mem_valid, mem_reg_wr, mem_mem_rd and mem_mem_wr go to 0. Data fields and flags are unchanged.
- Stall (no flush): all registers, including flags, hold their values.
- Flag update happens only on a load edge with ex_valid=1. Z = (result==0), N = result[DW-1], V = ex_ovf.
  - ADD, SUB: update N, V and Z.
  - XOR, SLL, SRA, ROR: update Z only; N and V hold.
  - All other opcodes, including RED and PADDSB: flags hold.
- Flags updated by instruction i are visible on `flags` in the cycle after i enters MEM, i.e. one cycle after the load edge.
- Halt:
  - A valid HLT loaded into MEM sets halted=1 on that edge; mem_valid=1 for that cycle only.
  - While halted=1, every later edge forces mem_valid and all enables to 0 and holds flags.
  - halted=1 persists until rst.
- Reset asserted mid-stall or mid-flush: reset wins that edge.

Decomposition:
- Shared package holds:
  - the 16 opcode constants;
  - the flag bit indices FLAG_N=2, FLAG_V=1, FLAG_Z=0;
  - a function returning the update mask for an opcode (ADD/SUB -> 3'b111; XOR/SLL/SRA/ROR -> 3'b001; others -> 3'b000).
- One natural sub-module, flag_reg: takes clk, rst, en, mask and new {N,V,Z}, and provides per-bit masked hold.

Test Plan:
- Reset, then a valid RED with ex_red_out=7'h40. Next cycle: mem_result=16'hFFC0, mem_valid=1, flags stay 3'b000.
- A valid ADD with ex_alu_out=16'h0000 and ex_ovf=1 gives flags=3'b011. A following valid XOR with ex_alu_out=16'h8001 gives flags=3'b010: Z clears, V holds, N is not updated.
- Load a valid SUB, then stall for 3 cycles while EX presents a RED with ex_red_out=7'h3F. mem_* and flags hold for all 3 cycles. After stall drops, mem_result=16'h003F and flags are unchanged by the RED.
- Assert flush and stall together with a valid SW in EX. Next cycle: mem_valid=0, mem_mem_wr=0, flags unchanged.
- A valid HLT is followed by a valid ADD with result 16'h0005. Expect halted=1, and mem_valid pulses 1 for exactly one cycle then stays 0. Flags stay unchanged despite the ADD; rst clears halted.
- With ex_valid=0 and ex_reg_wr=1: mem_valid=0, mem_reg_wr=0, flags unchanged.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - opcode constants, flag indices and flag update mask for the EX/MEM stage
package ex_mem_reg_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Which of {N,V,Z} an opcode is allowed to write.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_reg_flag_reg.sv
// rtl/ex_mem_reg_flag_reg.sv - architectural {N,V,Z} register with per-bit masked update
module flag_reg
  import ex_mem_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mask,
  input  logic [2:0] flags_new,
  output logic [2:0] flags
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < 3; i++) begin
      if (en && mask[i]) begin
        flags_d[i] = flags_new[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall, flush, sticky halt and flag ownership
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 7,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_alu_out,
  input  logic [RW-1:0] ex_red_out,
  input  logic          ex_ovf,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_reg_wr,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic [DW-1:0] ex_store_data,
  output logic          mem_valid,
  output logic [DW-1:0] mem_result,
  output logic [AW-1:0] mem_rd,
  output logic          mem_reg_wr,
  output logic          mem_mem_rd,
  output logic          mem_mem_wr,
  output logic [DW-1:0] mem_store_data,
  output logic [2:0]    flags,
  output logic          halted
);

  logic          valid_q, valid_d;
  logic [DW-1:0] result_q, result_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          reg_wr_q, reg_wr_d;
  logic          mrd_q, mrd_d;
  logic          mwr_q, mwr_d;
  logic [DW-1:0] sdata_q, sdata_d;
  logic          halted_q, halted_d;

  logic [DW-1:0] ex_result;
  logic [2:0]    flags_new;
  logic          flag_en;

  always_comb begin
    ex_result = ex_alu_out;
    if (ex_opcode == OP_RED) begin
      ex_result = {{(DW-RW){ex_red_out[RW-1]}}, ex_red_out};
    end
  end

  always_comb begin
    flags_new         = 3'b000;
    flags_new[FLAG_N] = ex_result[DW-1];
    flags_new[FLAG_V] = ex_ovf;
    flags_new[FLAG_Z] = (ex_result == '0);
  end

  // Halt outranks flush, flush outranks stall; data fields only move on a load.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    reg_wr_d = reg_wr_q;
    mrd_d    = mrd_q;
    mwr_d    = mwr_q;
    sdata_d  = sdata_q;
    halted_d = halted_q;
    flag_en  = 1'b0;
    if (halted_q || flush) begin
      valid_d  = 1'b0;
      reg_wr_d = 1'b0;
      mrd_d    = 1'b0;
      mwr_d    = 1'b0;
    end else if (!stall) begin
      valid_d  = ex_valid;
      result_d = ex_result;
      rd_d     = ex_rd;
      reg_wr_d = ex_valid & ex_reg_wr;
      mrd_d    = ex_valid & ex_mem_rd;
      mwr_d    = ex_valid & ex_mem_wr;
      sdata_d  = ex_store_data;
      flag_en  = ex_valid;
      if (ex_valid && (ex_opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      reg_wr_q <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      sdata_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      reg_wr_q <= reg_wr_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      sdata_q  <= sdata_d;
      halted_q <= halted_d;
    end
  end

  flag_reg u_flag_reg (
    .clk       (clk),
    .rst       (rst),
    .en        (flag_en),
    .mask      (flag_mask(ex_opcode)),
    .flags_new (flags_new),
    .flags     (flags)
  );

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_rd         = rd_q;
  assign mem_reg_wr     = reg_wr_q;
  assign mem_mem_rd     = mrd_q;
  assign mem_mem_wr     = mwr_q;
  assign mem_store_data = sdata_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - directed-vector bench for the EX/MEM pipeline register
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_alu_out;
  logic [6:0]  ex_red_out;
  logic        ex_ovf;
  logic [3:0]  ex_rd;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [15:0] ex_store_data;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic [3:0]  mem_rd;
  logic        mem_reg_wr, mem_mem_rd, mem_mem_wr;
  logic [15:0] mem_store_data;
  logic [2:0]  flags;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_alu_out     (ex_alu_out),
    .ex_red_out     (ex_red_out),
    .ex_ovf         (ex_ovf),
    .ex_rd          (ex_rd),
    .ex_reg_wr      (ex_reg_wr),
    .ex_mem_rd      (ex_mem_rd),
    .ex_mem_wr      (ex_mem_wr),
    .ex_store_data  (ex_store_data),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_rd         (mem_rd),
    .mem_reg_wr     (mem_reg_wr),
    .mem_mem_rd     (mem_mem_rd),
    .mem_mem_wr     (mem_mem_wr),
    .mem_store_data (mem_store_data),
    .flags          (flags),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                       input logic [6:0] red, input logic ovf, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [15:0] sd);
    ex_valid      = v;
    ex_opcode     = op;
    ex_alu_out    = alu;
    ex_red_out    = red;
    ex_ovf        = ovf;
    ex_rd         = rd;
    ex_reg_wr     = rw;
    ex_mem_rd     = mr;
    ex_mem_wr     = mw;
    ex_store_data = sd;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 4'h0, 16'h1234, 7'h00, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    check("rst_valid",  32'(mem_valid), 32'h0);
    check("rst_result", 32'(mem_result), 32'h0);
    check("rst_regwr",  32'(mem_reg_wr), 32'h0);
    check("rst_flags",  32'(flags), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // RED sign extension
    drive(1'b1, 4'h3, 16'h0000, 7'h40, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check("red_result", 32'(mem_result), 32'hFFC0);
    check("red_valid",  32'(mem_valid), 32'h1);
    check("red_regwr",  32'(mem_reg_wr), 32'h1);
    check("red_rd",     32'(mem_rd), 32'h2);
    check("red_flags",  32'(flags), 32'h0);

    drive(1'b1, 4'h0, 16'h0000, 7'h00, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check("add_flags",  32'(flags), 32'h3);
    check("add_result", 32'(mem_result), 32'h0);

    drive(1'b1, 4'h2, 16'h8001, 7'h00, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check("xor_flags", 32'(flags), 32'h2);

    drive(1'b1, 4'h1, 16'h8000, 7'h00, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check("sub_flags",  32'(flags), 32'h4);
    check("sub_result", 32'(mem_result), 32'h8000);

    // stall three cycles with a RED waiting in EX
    stall = 1'b1;
    drive(1'b1, 4'h3, 16'h0000, 7'h3F, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_result", 32'(mem_result), 32'h8000);
      check("stall_rd",     32'(mem_rd), 32'h5);
      check("stall_flags",  32'(flags), 32'h4);
    end
    stall = 1'b0;
    step();
    check("unstall_result", 32'(mem_result), 32'h003F);
    check("unstall_rd",     32'(mem_rd), 32'h7);
    check("unstall_flags",  32'(flags), 32'h4);

    // flush together with stall squashes a store
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 4'h9, 16'h00AA, 7'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
    step();
    check("flush_valid",  32'(mem_valid), 32'h0);
    check("flush_memwr",  32'(mem_mem_wr), 32'h0);
    check("flush_regwr",  32'(mem_reg_wr), 32'h0);
    check("flush_result", 32'(mem_result), 32'h003F);
    check("flush_sdata",  32'(mem_store_data), 32'h0);
    check("flush_flags",  32'(flags), 32'h4);

    stall = 1'b0;
    drive(1'b1, 4'h0, 16'h0000, 7'h00, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check("flush_add_flags", 32'(flags), 32'h4);
    flush = 1'b0;

    // bubble with stray write enable
    drive(1'b0, 4'h0, 16'h0000, 7'h00, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check("bubble_valid", 32'(mem_valid), 32'h0);
    check("bubble_regwr", 32'(mem_reg_wr), 32'h0);
    check("bubble_flags", 32'(flags), 32'h4);

    drive(1'b1, 4'h9, 16'h0040, 7'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    step();
    check("sw_memwr",  32'(mem_mem_wr), 32'h1);
    check("sw_sdata",  32'(mem_store_data), 32'hBEEF);
    check("sw_result", 32'(mem_result), 32'h0040);
    check("sw_flags",  32'(flags), 32'h4);

    // halt is sticky and blocks the following ADD
    drive(1'b1, 4'hF, 16'h0000, 7'h00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    check("hlt_halted", 32'(halted), 32'h1);
    check("hlt_valid",  32'(mem_valid), 32'h1);
    drive(1'b1, 4'h0, 16'h0005, 7'h00, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    check("halt_valid",  32'(mem_valid), 32'h0);
    check("halt_regwr",  32'(mem_reg_wr), 32'h0);
    check("halt_flags",  32'(flags), 32'h4);
    check("halt_sticky", 32'(halted), 32'h1);
    step();
    check("halt_valid2",  32'(mem_valid), 32'h0);
    check("halt_sticky2", 32'(halted), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("clr_halted", 32'(halted), 32'h0);
    check("clr_flags",  32'(flags), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
